// File: rtl/button_debouncer.sv
// button_debouncer: multi-channel two-flop synchronizer and tick-based
// debouncer for push-button pads. A shared prescaler provides the sample
// tick; each channel runs an independent LOW/RISE/HIGH/FALL FSM.
// Optional long-press output enabled by defining DEBOUNCE_HOLD_EN; otherwise
// held_buttons is tied low.
module button_debouncer #(
  parameter int unsigned N_BTN        = 4,
  parameter int unsigned TICK_DIV     = 100000,
  parameter int unsigned STABLE_TICKS = 10,
  parameter int unsigned HOLD_TICKS   = 500
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] raw_buttons,
  output logic [N_BTN-1:0] clean_buttons,
  output logic             busy,
  output logic [N_BTN-1:0] held_buttons
);

  localparam int unsigned DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned CNT_W = $clog2(STABLE_TICKS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

  typedef enum logic [1:0] {
    S_LOW,
    S_RISE,
    S_HIGH,
    S_FALL
  } state_t;

  logic [N_BTN-1:0] sync_q1;
  logic [N_BTN-1:0] sync_q2;
  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  state_t           state [N_BTN];
  logic [CNT_W-1:0] cnt   [N_BTN];
  logic [N_BTN-1:0] pending;
  logic [N_BTN-1:0] rise_done;
  logic [N_BTN-1:0] fall_done;

  assign tick = (div_cnt == DIV_LAST);

  // Two-flop synchronizer bringing the asynchronous pads into the clk domain
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= raw_buttons;
      sync_q2 <= sync_q1;
    end
  end

  // Shared prescaler: counts 0..TICK_DIV-1, tick on the last count
  always_ff @(posedge clk) begin
    if (rst || tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // Per-channel status: candidate pending, and the final accepting tick of a rise/fall
  always_comb begin
    pending   = '0;
    rise_done = '0;
    fall_done = '0;
    for (int unsigned i = 0; i < N_BTN; i++) begin
      pending[i]   = (state[i] == S_RISE) || (state[i] == S_FALL);
      rise_done[i] = (state[i] == S_RISE) &&  sync_q2[i] && tick && (cnt[i] == CNT_LAST);
      fall_done[i] = (state[i] == S_FALL) && !sync_q2[i] && tick && (cnt[i] == CNT_LAST);
    end
  end

  // Debounce FSMs; a mismatch takes priority over a tick in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      clean_buttons <= '0;
      for (int unsigned i = 0; i < N_BTN; i++) begin
        state[i] <= S_LOW;
        cnt[i]   <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < N_BTN; i++) begin
        case (state[i])
          S_LOW: begin
            if (sync_q2[i]) begin
              state[i] <= S_RISE;
              cnt[i]   <= '0;
            end
          end
          S_RISE: begin
            if (!sync_q2[i]) begin
              state[i] <= S_LOW;
              cnt[i]   <= '0;
            end else if (tick) begin
              cnt[i] <= cnt[i] + CNT_W'(1);
              if (rise_done[i]) begin
                state[i]         <= S_HIGH;
                clean_buttons[i] <= 1'b1;
              end
            end
          end
          S_HIGH: begin
            if (!sync_q2[i]) begin
              state[i] <= S_FALL;
              cnt[i]   <= '0;
            end
          end
          S_FALL: begin
            if (sync_q2[i]) begin
              state[i] <= S_HIGH;
              cnt[i]   <= '0;
            end else if (tick) begin
              cnt[i] <= cnt[i] + CNT_W'(1);
              if (fall_done[i]) begin
                state[i]         <= S_LOW;
                clean_buttons[i] <= 1'b0;
              end
            end
          end
          default: begin
            state[i] <= S_LOW;
            cnt[i]   <= '0;
          end
        endcase
      end
    end
  end

  // busy reflects any channel with a change in progress, one cycle behind the state
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
    end else begin
      busy <= |pending;
    end
  end

`ifdef DEBOUNCE_HOLD_EN
  localparam int unsigned HOLD_W = $clog2(HOLD_TICKS + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(HOLD_TICKS);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_TICKS - 1);

  logic [HOLD_W-1:0] hold_cnt [N_BTN];

  // Long-press timer: counts ticks while pressed, saturates, clears as clean falls
  always_ff @(posedge clk) begin
    if (rst) begin
      held_buttons <= '0;
      for (int unsigned i = 0; i < N_BTN; i++) begin
        hold_cnt[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < N_BTN; i++) begin
        if (fall_done[i]) begin
          hold_cnt[i]     <= '0;
          held_buttons[i] <= 1'b0;
        end else if (tick && ((state[i] == S_HIGH) || (state[i] == S_FALL))
                     && (hold_cnt[i] != HOLD_MAX)) begin
          hold_cnt[i] <= hold_cnt[i] + HOLD_W'(1);
          if (hold_cnt[i] == HOLD_LAST) begin
            held_buttons[i] <= 1'b1;
          end
        end
      end
    end
  end
`else
  assign held_buttons = '0;
`endif

endmodule

// File: doc/button_debouncer.md
Name: button_debouncer

Overview:
Multi-channel synchronizer and debouncer for the whack-a-mole push-buttons. It sits directly upstream of the per-button edge detector. It takes asynchronous, bouncing pad inputs and produces clean, stable levels in the clk domain, which the edge detector turns into one-cycle press pulses. A shared tick prescaler sets the debounce time base.

Parameters:
N_BTN, 4, number of independent button channels
TICK_DIV, 100000, clk cycles per sample tick (1 ms at 100 MHz); must be >= 1
STABLE_TICKS, 10, consecutive ticks a new level must persist before it is accepted; must be >= 1
HOLD_TICKS, 500, ticks of continuous press before held_buttons asserts (optional feature only)

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
raw_buttons  input  N_BTN  raw pad levels, asynchronous, active high
clean_buttons  output  N_BTN  debounced level per channel, registered
busy  output  1  OR over channels of "candidate change pending", registered
held_buttons  output  N_BTN  long-press level per channel (see Optional Feature)

Behaviour:
- One clock; reset is synchronous and active-high; all state is updated on posedge clk only.
- Reset (rst=1 at a clock edge) does the following:
  - sync flops, prescaler, all per-channel counters and FSMs go to S_LOW/0.
  - clean_buttons=0, busy=0, held_buttons=0.
  - Reset mid-debounce discards progress.
- Synchronizer: two flops per channel; sync[i] lags raw_buttons[i] by 2 cycles.
- Prescaler: counter 0..TICK_DIV-1. tick=1 for one cycle when counter==TICK_DIV-1, then wraps to 0. TICK_DIV=1 gives tick every cycle.
- Per-channel FSM, independent per channel, with a shared tick:
  - S_LOW (clean=0): sync=1 -> S_RISE, cnt=0.
  - S_RISE:
    - sync=0 -> S_LOW, cnt=0 (glitch rejected).
    - Otherwise on tick cnt++.
    - On the tick that makes cnt==STABLE_TICKS -> S_HIGH, and clean goes 1 on that edge.
  - S_HIGH (clean=1): sync=0 -> S_FALL, cnt=0.
  - S_FALL:
    - sync=1 -> S_HIGH, cnt=0.
    - Otherwise count ticks.
    - At STABLE_TICKS ticks -> S_LOW, and clean goes 0.
- Simultaneous events:
  - Mismatch and tick in the same cycle: mismatch wins and the tick is not counted.
  - A tick in the cycle the FSM enters S_RISE/S_FALL is not counted.
- Latency from a stable raw edge to clean change: between (STABLE_TICKS-1)*TICK_DIV+3 and STABLE_TICKS*TICK_DIV+3 cycles.
- busy: registered OR of (state==S_RISE or S_FALL) over all channels, one cycle behind the state.
- Counter width: $clog2(STABLE_TICKS+1); the counter never wraps.
- Raw input held high through reset release: the channel debounces up normally after reset, and downstream sees a press. This is intended.

Optional Feature:
Macro DEBOUNCE_HOLD_EN.
- Defined:
  - Per-channel hold counter, width $clog2(HOLD_TICKS+1).
  - Counts ticks while the channel is in S_HIGH or S_FALL; saturates at HOLD_TICKS.
  - held_buttons[i] goes 1 on the edge the counter reaches HOLD_TICKS.
  - Counter and held_buttons[i] clear on the same edge clean_buttons[i] falls.
  - Cleared by rst.
- Undefined: no hold counters; held_buttons is tied to 0. The port list is unchanged.

Test Plan:
All tests use TICK_DIV=4, STABLE_TICKS=3, HOLD_TICKS=8, N_BTN=4.
1. Reset: raw=4'b1111 with rst=1 for 3 cycles -> clean=0, busy=0, held=0 during reset. After release, clean=4'b1111 within 15 cycles.
2. Clean press: raw[0] 0->1 at cycle t, held high -> clean[0] rises in [t+11, t+15]; busy=1 during the interval; clean[3:1] stay 0.
3. Glitch rejection: raw[1] high for 6 cycles then low -> clean[1] never rises; busy returns to 0 within 4 cycles of raw falling.
4. Bouncy release: raw[2] stable high, then toggles every 2 cycles for 20 cycles, then held 0 -> clean[2] stays 1 during bouncing and falls within 15 cycles after the final 1->0.
5. Independence: raw[0] and raw[3] rise on the same cycle, raw[3] glitches once at +5 -> clean[0] rises on schedule; clean[3] rises 3 ticks after its last re-rise.
6. Hold (DEBOUNCE_HOLD_EN): raw[0] held high for 60 cycles -> held[0]=1 exactly 8 ticks after clean[0] rose; both clear on the same edge after release. With the macro undefined, held=0 throughout.
